// File: rtl/rr_mux_2to1_stage_pkg.sv
// -----------------------------------------------------------------------------
// rr_mux_pkg
// Shared definitions for the two-channel round-robin select stage:
//   SEL_IN0 / SEL_IN1 : mux select encodings (0 = channel 0, 1 = channel 1)
//   DEFAULT_W         : default word width
//   GNT_CNT_W / MAX   : width and saturation value of the optional grant
//                       counters (built when RR_MUX_GRANT_CNT_EN is defined)
//   sat_inc()         : saturating increment for those counters
// -----------------------------------------------------------------------------
package rr_mux_pkg;

  localparam logic SEL_IN0 = 1'b0;
  localparam logic SEL_IN1 = 1'b1;

  localparam int DEFAULT_W = 4;

  localparam int                   GNT_CNT_W   = 8;
  localparam logic [GNT_CNT_W-1:0] GNT_CNT_MAX = 8'hFF;

  function automatic logic [GNT_CNT_W-1:0] sat_inc(input logic [GNT_CNT_W-1:0] v);
    return (v == GNT_CNT_MAX) ? v : v + GNT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/rr_mux_2to1_stage_if.sv
// -----------------------------------------------------------------------------
// rr_mux_2to1_stage_if
// Bundles the two producer channels and the single consumer channel of the
// round-robin stage.
//
// Handshake: a word moves across a channel on a rising clk edge where both
// valid and ready are high. A producer raises valid with its data and holds
// both unchanged until it sees ready; ready may depend combinationally on
// valid, valid never depends on ready.
//
// Signals:
//   in0_valid/in0_ready/in0_data  channel 0 producer
//   in1_valid/in1_ready/in1_data  channel 1 producer
//   out_valid/out_ready/out_data  consumer side, registered word
//   out_sel                       source channel of out_data
// Modports:
//   slave  : the stage (accepts producers, drives the consumer)
//   master : the environment (producers and consumer)
// -----------------------------------------------------------------------------
interface rr_mux_2to1_stage_if
  import rr_mux_pkg::*;
#(
  parameter int W = DEFAULT_W
);

  logic         in0_valid;
  logic         in0_ready;
  logic [W-1:0] in0_data;
  logic         in1_valid;
  logic         in1_ready;
  logic [W-1:0] in1_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_sel;

  modport slave (
    input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
    output in0_ready, in1_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, out_ready,
    input  in0_ready, in1_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/rr_mux_2to1_stage_mux.sv
// -----------------------------------------------------------------------------
// mux_2to1_w
// Pure combinational W-bit 2:1 word mux (same function as the 6:3 and 8:4
// muxes at W=3 and W=4).
// Ports:
//   in0, in1 : candidate words
//   sel      : 0 selects in0, 1 selects in1
//   y        : selected word
// -----------------------------------------------------------------------------
module mux_2to1_w #(
  parameter int W = 4
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic         sel,
  output logic [W-1:0] y
);

  assign y = sel ? in1 : in0;

endmodule

// File: rtl/rr_mux_2to1_stage.sv
// -----------------------------------------------------------------------------
// rr_mux_2to1_stage
// Registered two-channel round-robin select stage. Grants one of two producers,
// steers its word through mux_2to1_w and registers it on a single valid/ready
// output. One word per cycle with out_ready held high.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   bus       rr_mux_2to1_stage_if.slave (in0_*, in1_*, out_*, out_sel)
//   gnt_cnt0  accepted-transfer count for channel 0, saturating  (optional)
//   gnt_cnt1  accepted-transfer count for channel 1, saturating  (optional)
//
// Build option: define RR_MUX_GRANT_CNT_EN to add gnt_cnt0/gnt_cnt1. The
// datapath and handshake are identical either way.
// -----------------------------------------------------------------------------
module rr_mux_2to1_stage
  import rr_mux_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_mux_2to1_stage_if.slave   bus
`ifdef RR_MUX_GRANT_CNT_EN
  ,
  output logic [GNT_CNT_W-1:0] gnt_cnt0,
  output logic [GNT_CNT_W-1:0] gnt_cnt1
`endif
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q,  out_data_d;
  logic         out_sel_q,   out_sel_d;
  // Channel granted on the most recent transfer; the other one wins a tie.
  logic         last_q,      last_d;

  logic         load_en;
  logic         any_valid;
  logic         grant;
  logic [W-1:0] mux_y;

  // The output register can take a word when it is empty or being drained.
  assign load_en   = !out_valid_q || bus.out_ready;
  assign any_valid = bus.in0_valid || bus.in1_valid;

  // Tie goes to the channel not served last; otherwise the lone requester.
  // With no requester grant is a don't-care and is gated off below.
  assign grant = (bus.in0_valid && bus.in1_valid) ? ~last_q : bus.in1_valid;

  mux_2to1_w #(.W(W)) u_mux (
    .in0 (bus.in0_data),
    .in1 (bus.in1_data),
    .sel (grant),
    .y   (mux_y)
  );

  // rst_n gating keeps both producers stalled for the whole reset cycle.
  assign bus.in0_ready = rst_n && load_en && bus.in0_valid && (grant == SEL_IN0);
  assign bus.in1_ready = rst_n && load_en && bus.in1_valid && (grant == SEL_IN1);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    last_d      = last_q;
    if (load_en) begin
      if (any_valid) begin
        out_valid_d = 1'b1;
        out_data_d  = mux_y;
        out_sel_d   = grant;
        last_d      = grant;
      end else begin
        // Drained with nothing to replace it; word and source are kept.
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= SEL_IN0;
      last_q      <= SEL_IN1;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      last_q      <= last_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

`ifdef RR_MUX_GRANT_CNT_EN
  logic [GNT_CNT_W-1:0] cnt0_q, cnt0_d;
  logic [GNT_CNT_W-1:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (bus.in0_ready) cnt0_d = sat_inc(cnt0_q);
    if (bus.in1_ready) cnt1_d = sat_inc(cnt1_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_rr_mux_2to1_stage.sv
// -----------------------------------------------------------------------------
// tb_rr_mux_2to1_stage
// Bench for rr_mux_2to1_stage. Default build uses W=4; with
// RR_MUX_GRANT_CNT_EN defined it uses W=3 and also exercises the grant
// counters (gnt_cnt0/gnt_cnt1).
// -----------------------------------------------------------------------------
module tb_rr_mux_2to1_stage;
  import rr_mux_pkg::*;

`ifdef RR_MUX_GRANT_CNT_EN
  localparam int W = 3;
`else
  localparam int W = DEFAULT_W;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_mux_2to1_stage_if #(.W(W)) bus ();

`ifdef RR_MUX_GRANT_CNT_EN
  logic [GNT_CNT_W-1:0] gnt_cnt0;
  logic [GNT_CNT_W-1:0] gnt_cnt1;
`endif

  rr_mux_2to1_stage #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus)
`ifdef RR_MUX_GRANT_CNT_EN
    ,
    .gnt_cnt0 (gnt_cnt0),
    .gnt_cnt1 (gnt_cnt1)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- producer rule checks ----------------
  logic chk_hold = 1'b0;

  property p_hold0;
    @(posedge clk) disable iff (!rst_n || !chk_hold)
      (bus.in0_valid && !bus.in0_ready) |=> (bus.in0_valid && $stable(bus.in0_data));
  endproperty
  property p_hold1;
    @(posedge clk) disable iff (!rst_n || !chk_hold)
      (bus.in1_valid && !bus.in1_ready) |=> (bus.in1_valid && $stable(bus.in1_data));
  endproperty
  a_hold0: assert property (p_hold0)
    else begin n_err++; $display("FAIL producer_hold0 at %0t", $time); end
  a_hold1: assert property (p_hold1)
    else begin n_err++; $display("FAIL producer_hold1 at %0t", $time); end

  // ---------------- reference model / scoreboard ----------------
  // Output-register contents, channel preferred on a tie, per-channel
  // saturating accept counts, and the queue of accepted words in order.
  bit           m_valid = 1'b0;
  logic [W-1:0] m_data  = '0;
  int           m_sel   = 0;
  int           m_pref  = 0;
  int           m_cnt [2] = '{0, 0};
  bit           exp_rdy [2] = '{1'b0, 1'b0};
  logic [W-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Entered 1 time unit after a rising edge; drives one cycle of inputs,
  // checks readies mid-cycle, then checks registered outputs after the edge.
  task automatic apply(input bit rst, input bit v0, input logic [W-1:0] d0,
                       input bit v1, input logic [W-1:0] d1, input bit ordy,
                       output bit r0_s, output bit r1_s);
    int win;
    logic [W-1:0] w;
    rst_n         = !rst;
    bus.in0_valid = v0;
    bus.in0_data  = d0;
    bus.in1_valid = v1;
    bus.in1_data  = d1;
    bus.out_ready = ordy;
    #1;
    win = -1;
    if (!rst && (!m_valid || ordy)) begin
      if (v0 && v1)  win = m_pref;
      else if (v0)   win = 0;
      else if (v1)   win = 1;
    end
    exp_rdy[0] = (win == 0);
    exp_rdy[1] = (win == 1);
    r0_s = bus.in0_ready;
    r1_s = bus.in1_ready;
    check("in0_ready", {31'd0, r0_s}, {31'd0, exp_rdy[0]});
    check("in1_ready", {31'd0, r1_s}, {31'd0, exp_rdy[1]});
    // A word the consumer takes this cycle must be the oldest accepted one.
    if (!rst && m_valid && ordy && exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check("out_word", 32'(bus.out_data), 32'(w));
    end
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_sel = 0; m_pref = 0;
      m_cnt   = '{0, 0};
      exp_q.delete();
    end else if (!m_valid || ordy) begin
      if (win >= 0) begin
        m_valid = 1'b1;
        m_data  = (win == 1) ? d1 : d0;
        m_sel   = win;
        m_pref  = 1 - win;
        if (m_cnt[win] < 255) m_cnt[win] = m_cnt[win] + 1;
        exp_q.push_back(m_data);
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
    check("out_data",  32'(bus.out_data), 32'(m_data));
    check("out_sel",   {31'd0, bus.out_sel}, 32'(m_sel));
`ifdef RR_MUX_GRANT_CNT_EN
    check("gnt_cnt0", 32'(gnt_cnt0), 32'(m_cnt[0]));
    check("gnt_cnt1", 32'(gnt_cnt1), 32'(m_cnt[1]));
`endif
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit       rst;
    bit       v0;
    logic [3:0] d0;
    bit       v1;
    logic [3:0] d1;
    bit       ordy;
    bit       r0;
    bit       r1;
    bit       ov;
    logic [3:0] od;
    bit       os;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl [NV];

  initial begin
    bit r0, r1;
    bit pv [2];
    bit pend [2];
    logic [W-1:0] pd [2];
    bit ordy, rst;

    bus.in0_valid = 1'b0; bus.in0_data = '0;
    bus.in1_valid = 1'b0; bus.in1_data = '0;
    bus.out_ready = 1'b0;

    //             rst v0 d0    v1 d1    ordy  r0 r1  ov od    os
    // reset with both valid, then first accept is in0
    tbl[0]  = '{1'b1,1'b1,4'hA,1'b1,4'h5,1'b1, 1'b0,1'b0, 1'b0,4'h0,1'b0};
    tbl[1]  = '{1'b1,1'b1,4'hA,1'b1,4'h5,1'b1, 1'b0,1'b0, 1'b0,4'h0,1'b0};
    tbl[2]  = '{1'b0,1'b1,4'hA,1'b1,4'h5,1'b1, 1'b1,1'b0, 1'b1,4'hA,1'b0};
    // contention: alternating grants, one word per cycle
    tbl[3]  = '{1'b0,1'b1,4'h6,1'b1,4'h9,1'b1, 1'b0,1'b1, 1'b1,4'h9,1'b1};
    tbl[4]  = '{1'b0,1'b1,4'h6,1'b1,4'h9,1'b1, 1'b1,1'b0, 1'b1,4'h6,1'b0};
    tbl[5]  = '{1'b0,1'b1,4'h6,1'b1,4'h9,1'b1, 1'b0,1'b1, 1'b1,4'h9,1'b1};
    tbl[6]  = '{1'b0,1'b1,4'h6,1'b1,4'h9,1'b1, 1'b1,1'b0, 1'b1,4'h6,1'b0};
    tbl[7]  = '{1'b0,1'b1,4'h6,1'b1,4'h9,1'b1, 1'b0,1'b1, 1'b1,4'h9,1'b1};
    tbl[8]  = '{1'b0,1'b1,4'h6,1'b1,4'h9,1'b1, 1'b1,1'b0, 1'b1,4'h6,1'b0};
    // load 0111 from in0, then backpressure for 3 cycles
    tbl[9]  = '{1'b0,1'b1,4'h7,1'b1,4'h9,1'b1, 1'b0,1'b1, 1'b1,4'h9,1'b1};
    tbl[10] = '{1'b0,1'b1,4'h7,1'b1,4'h3,1'b1, 1'b1,1'b0, 1'b1,4'h7,1'b0};
    tbl[11] = '{1'b0,1'b1,4'h2,1'b1,4'h3,1'b0, 1'b0,1'b0, 1'b1,4'h7,1'b0};
    tbl[12] = '{1'b0,1'b1,4'h2,1'b1,4'h3,1'b0, 1'b0,1'b0, 1'b1,4'h7,1'b0};
    tbl[13] = '{1'b0,1'b1,4'h2,1'b1,4'h3,1'b0, 1'b0,1'b0, 1'b1,4'h7,1'b0};
    // release: grant goes to the channel opposite the held word
    tbl[14] = '{1'b0,1'b1,4'h2,1'b1,4'h3,1'b1, 1'b0,1'b1, 1'b1,4'h3,1'b1};
    tbl[15] = '{1'b0,1'b1,4'h2,1'b0,4'h0,1'b1, 1'b1,1'b0, 1'b1,4'h2,1'b0};
    // in1 only for 3 words, then idle
    tbl[16] = '{1'b0,1'b0,4'h0,1'b1,4'hD,1'b1, 1'b0,1'b1, 1'b1,4'hD,1'b1};
    tbl[17] = '{1'b0,1'b0,4'h0,1'b1,4'hD,1'b1, 1'b0,1'b1, 1'b1,4'hD,1'b1};
    tbl[18] = '{1'b0,1'b0,4'h0,1'b1,4'hD,1'b1, 1'b0,1'b1, 1'b1,4'hD,1'b1};
    tbl[19] = '{1'b0,1'b0,4'h0,1'b0,4'h0,1'b1, 1'b0,1'b0, 1'b0,4'hD,1'b1};
    tbl[20] = '{1'b0,1'b0,4'h0,1'b0,4'h0,1'b1, 1'b0,1'b0, 1'b0,4'hD,1'b1};
    // mid-operation reset drops 1100, then in0 wins contention
    tbl[21] = '{1'b0,1'b1,4'hC,1'b0,4'h0,1'b1, 1'b1,1'b0, 1'b1,4'hC,1'b0};
    tbl[22] = '{1'b1,1'b0,4'h0,1'b0,4'h0,1'b0, 1'b0,1'b0, 1'b0,4'h0,1'b0};
    tbl[23] = '{1'b0,1'b1,4'h2,1'b1,4'h4,1'b1, 1'b1,1'b0, 1'b1,4'h2,1'b0};

    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      apply(tbl[i].rst, tbl[i].v0, W'(tbl[i].d0), tbl[i].v1, W'(tbl[i].d1),
            tbl[i].ordy, r0, r1);
      check($sformatf("tbl%0d_in0_ready", i), {31'd0, r0}, {31'd0, tbl[i].r0});
      check($sformatf("tbl%0d_in1_ready", i), {31'd0, r1}, {31'd0, tbl[i].r1});
      check($sformatf("tbl%0d_out_valid", i), {31'd0, bus.out_valid}, {31'd0, tbl[i].ov});
      check($sformatf("tbl%0d_out_data", i), 32'(bus.out_data), 32'(W'(tbl[i].od)));
      check($sformatf("tbl%0d_out_sel", i), {31'd0, bus.out_sel}, {31'd0, tbl[i].os});
    end

    // ---------------- randomized traffic against the model ----------------
    apply(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, r0, r1);
    chk_hold = 1'b1;
    pend = '{1'b0, 1'b0};
    pv   = '{1'b0, 1'b0};
    pd   = '{'0, '0};
    for (int n = 0; n < 2000; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (!pend[c]) begin
          pv[c] = ($urandom_range(0, 99) < 60);
          pd[c] = W'($urandom);
        end
      end
      ordy = ($urandom_range(0, 99) < 70);
      rst  = ($urandom_range(0, 199) == 0);
      apply(rst, pv[0], pd[0], pv[1], pd[1], ordy, r0, r1);
      for (int c = 0; c < 2; c++) pend[c] = pv[c] && !exp_rdy[c];
    end
    chk_hold = 1'b0;

    // stall that never resolves must not flip priority: after a long stall
    // with both valid, the release grants the channel opposite out_sel
    apply(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, r0, r1);
    apply(1'b0, 1'b1, W'(5), 1'b0, '0, 1'b0, r0, r1);
    for (int k = 0; k < 5; k++) apply(1'b0, 1'b1, W'(6), 1'b1, W'(1), 1'b0, r0, r1);
    apply(1'b0, 1'b1, W'(6), 1'b1, W'(1), 1'b1, r0, r1);
    check("stall_release_grant", {31'd0, bus.out_sel}, 32'd1);

`ifdef RR_MUX_GRANT_CNT_EN
    // grant counters: 300 in0 transfers saturate, then 2 in1 transfers
    apply(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, r0, r1);
    for (int k = 0; k < 300; k++) apply(1'b0, 1'b1, W'(2), 1'b0, '0, 1'b1, r0, r1);
    for (int k = 0; k < 2; k++)   apply(1'b0, 1'b0, '0, 1'b1, W'(k + 3), 1'b1, r0, r1);
    check("gnt_cnt0_saturated", 32'(gnt_cnt0), 32'd255);
    check("gnt_cnt1_two",       32'(gnt_cnt1), 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
